// File: rtl/tx_dec_formatter.sv
// tx_dec_formatter: turns an operand into a signed/unsigned decimal ASCII
// frame for a UART transmitter, with a banner line sent after reset.
module tx_dec_formatter #(
  parameter int DBIT        = 8,
  parameter int SIGNED_MODE = 1,
  parameter int PAD_ZEROS   = 0,
  parameter int EOL_CRLF    = 1,
  parameter int BANNER      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_done_tick,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] leds,
  output logic [7:0]      d_in,
  output logic            tx_start,
  output logic            rd,
  output logic            busy
);

  // Decimal digit count of the largest unsigned DBIT-bit value.
  function automatic int ndig_f(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 1;
    v = v / 10;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  localparam int NDIG = ndig_f(DBIT);
  localparam int BW   = 4 * NDIG;

  localparam logic [2:0] S_BANNER  = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_SIGN    = 3'd3;
  localparam logic [2:0] S_DIGIT   = 3'd4;
  localparam logic [2:0] S_EOL_CR  = 3'd5;
  localparam logic [2:0] S_EOL_LF  = 3'd6;

  logic [2:0]      state;
  logic [DBIT-1:0] operand;    // magnitude, shifted out MSB-first while converting
  logic [BW-1:0]   bcd;
  logic [2:0]      idx;        // banner char index or current BCD digit
  logic [4:0]      cnt;        // conversion cycle counter
  logic            neg;
  logic            started;    // a significant digit has already been sent
  logic            in_banner;  // current EOL belongs to the banner (no rd)

  logic            neg_in;
  logic [DBIT-1:0] mag_in;
  logic [BW-1:0]   bcd_adj;
  logic [3:0]      cur_digit;
  logic [7:0]      ch;
  logic            skip;
  logic            accept;

  // Sign detection and two's-complement magnitude of the incoming operand;
  // the most negative value wraps to 2^(DBIT-1), which is the wanted magnitude.
  assign neg_in = (SIGNED_MODE != 0) && leds[DBIT-1];
  assign mag_in = neg_in ? (~leds + DBIT'(1)) : leds;

  assign accept = tx_start && tx_done_tick;
  assign busy   = (state != S_IDLE);

  // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++)
      if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Select the BCD digit addressed by idx.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NDIG; i++)
      if (idx == 3'(i)) cur_digit = bcd[4*i +: 4];
  end

  // Character that the current state wants to send.
  always_comb begin
    ch = 8'h00;
    case (state)
      S_BANNER: begin
        case (idx)
          3'd0:    ch = 8'h54;  // 'T'
          3'd1:    ch = 8'h50;  // 'P'
          3'd2:    ch = 8'h20;  // ' '
          3'd3:    ch = 8'h32;  // '2'
          default: ch = 8'h3A;  // ':'
        endcase
      end
      S_SIGN:   ch = 8'h2D;
      S_DIGIT:  ch = {4'h3, cur_digit};
      S_EOL_CR: ch = 8'h0D;
      S_EOL_LF: ch = 8'h0A;
      default:  ch = 8'h00;
    endcase
  end

  // Leading zeros are dropped one per cycle; the units digit is never dropped.
  assign skip = (state == S_DIGIT) && (PAD_ZEROS == 0) && !started &&
                (idx != 3'd0) && (cur_digit == 4'd0);

  // Frame sequencer and transmitter handshake. A character is presented only
  // while tx_start is low, so the cycle after each accepted character always
  // has tx_start low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= (BANNER != 0) ? S_BANNER : S_IDLE;
      in_banner <= (BANNER != 0);
      d_in      <= 8'h00;
      tx_start  <= 1'b0;
      rd        <= 1'b0;
      operand   <= '0;
      bcd       <= '0;
      idx       <= 3'd0;
      cnt       <= 5'd0;
      neg       <= 1'b0;
      started   <= 1'b0;
    end else begin
      rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_empty) begin
            operand <= mag_in;
            neg     <= neg_in;
            bcd     <= '0;
            cnt     <= 5'd0;
            state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd     <= {bcd_adj[BW-2:0], operand[DBIT-1]};
          operand <= {operand[DBIT-2:0], 1'b0};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'(DBIT-1)) begin
            state   <= neg ? S_SIGN : S_DIGIT;
            idx     <= 3'(NDIG-1);
            started <= 1'b0;
          end
        end
        S_BANNER, S_SIGN, S_DIGIT, S_EOL_CR, S_EOL_LF: begin
          if (accept) begin
            tx_start <= 1'b0;
            case (state)
              S_BANNER: begin
                if (idx == 3'd4) begin
                  idx   <= 3'd0;
                  state <= S_EOL_CR;
                end else begin
                  idx <= idx + 3'd1;
                end
              end
              S_SIGN: state <= S_DIGIT;
              S_DIGIT: begin
                started <= 1'b1;
                if (idx == 3'd0) state <= S_EOL_CR;
                else             idx   <= idx - 3'd1;
              end
              S_EOL_CR: begin
                if (EOL_CRLF != 0) begin
                  state <= S_EOL_LF;
                end else begin
                  state     <= S_IDLE;
                  rd        <= !in_banner;
                  in_banner <= 1'b0;
                end
              end
              default: begin
                state     <= S_IDLE;
                rd        <= !in_banner;
                in_banner <= 1'b0;
              end
            endcase
          end else if (!tx_start) begin
            if (skip) begin
              idx <= idx - 3'd1;
            end else begin
              d_in     <= ch;
              tx_start <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_dec_formatter.sv
// Bench for tx_dec_formatter: a default instance and a 16-bit unsigned,
// zero-padded, CR-only instance, each served by a transmitter model that
// answers tx_start after 10 cycles. Expected characters (256 = rd pulse)
// are queued by the stimulus and consumed by the monitor.
module tb_tx_dec_formatter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rx, spur, done, txs, rds, busys, tdt;
  logic [7:0]  leds0;
  logic [15:0] leds1;
  logic [7:0]  din0, din1;
  int          q[2][$];
  int          cnt[2];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;
  assign tdt = done | spur;

  tx_dec_formatter u0 (
    .clk(clk), .reset(rst), .tx_done_tick(tdt[0]), .rx_empty(rx[0]), .leds(leds0),
    .d_in(din0), .tx_start(txs[0]), .rd(rds[0]), .busy(busys[0]));

  tx_dec_formatter #(.DBIT(16), .SIGNED_MODE(0), .PAD_ZEROS(1), .EOL_CRLF(0)) u1 (
    .clk(clk), .reset(rst), .tx_done_tick(tdt[1]), .rx_empty(rx[1]), .leds(leds1),
    .d_in(din1), .tx_start(txs[1]), .rd(rds[1]), .busy(busys[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input int k, input int act, input string nm);
    if (q[k].size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d %s: got 0x%0h with nothing expected", k, nm, act);
    end else begin
      chk($sformatf("dut%0d %s", k, nm), act, q[k].pop_front());
    end
  endtask

  task automatic push_str(input int k, input string s);
    for (int i = 0; i < s.len(); i++) q[k].push_back(int'(s[i]));
  endtask

  task automatic push_eol(input int k, input bit with_rd);
    q[k].push_back(13);
    if (k == 0) q[k].push_back(10);
    if (with_rd) q[k].push_back(256);
  endtask

  task automatic push_banner(input int k);
    push_str(k, "TP 2:");
    push_eol(k, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (!(q[0].size() == 0 && q[1].size() == 0 && busys == 2'b00) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("wait_idle in budget", int'(i < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  // One frame request with a spurious tx_done_tick injected during CONVERT.
  task automatic frame(input int k, input logic [15:0] v, input string s);
    push_str(k, s);
    push_eol(k, 1'b1);
    @(posedge clk); #2;
    if (k == 0) leds0 = v[7:0];
    else        leds1 = v;
    rx[k] = 1'b1;
    @(posedge clk); #2 rx[k] = 1'b0;
    @(posedge clk); #2 spur[k] = 1'b1;
    @(posedge clk); #2 spur[k] = 1'b0;
    wait_idle(3000);
  endtask

  // Transmitter model and monitor for both instances.
  initial begin
    done = 2'b00;
    cnt[0] = 0;
    cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          cnt[k]  = 0;
          done[k] = 1'b0;
        end else begin
          if (done[k]) begin
            done[k] = 1'b0;
            cnt[k]  = 0;
            chk($sformatf("dut%0d gap after done", k), int'(txs[k]), 0);
          end else if (txs[k]) begin
            cnt[k]++;
            if (cnt[k] == 10) begin
              done[k] = 1'b1;
              pop_chk(k, (k == 0) ? int'(din0) : int'(din1), "char");
            end
          end
          if (rds[k]) pop_chk(k, 256, "rd");
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bit found;
    rst = 1'b1; rx = 2'b00; spur = 2'b00; leds0 = '0; leds1 = '0;
    push_banner(0);
    push_banner(1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx_start", int'(txs), 0);
    chk("reset d_in0", int'(din0), 0);
    chk("reset d_in1", int'(din1), 0);
    chk("reset rd", int'(rds), 0);
    chk("reset busy (banner)", int'(busys), 3);
    @(posedge clk); #2 rst = 1'b0;
    wait_idle(3000);
    chk("idle after banner", int'(busys), 0);

    frame(0, 16'h007B, "123");
    frame(0, 16'h0080, "-128");
    frame(0, 16'h00FF, "-1");
    frame(0, 16'h0000, "0");
    frame(0, 16'h0064, "100");
    frame(0, 16'h007F, "127");
    frame(1, 16'h0005, "00005");
    frame(1, 16'hFFFF, "65535");

    // rx_empty held through a whole frame: one frame, then a restart right after rd.
    push_str(0, "123"); push_eol(0, 1'b1);
    push_str(0, "123"); push_eol(0, 1'b1);
    @(posedge clk); #2;
    leds0 = 8'h7B;
    rx[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rds[0]) begin found = 1'b1; break; end
    end
    chk("held rd seen", int'(found), 1);
    chk("held idle at rd", int'(busys[0]), 0);
    @(negedge clk);
    chk("held restart after rd", int'(busys[0]), 1);
    rx[0] = 1'b0;
    wait_idle(3000);

    // Reset while '2' is pending aborts the frame; the banner restarts at 'T'.
    push_str(0, "123"); push_eol(0, 1'b1);
    @(posedge clk); #2;
    leds0 = 8'h7B;
    rx[0] = 1'b1;
    @(posedge clk); #2 rx[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (txs[0] && din0 == 8'h32) begin found = 1'b1; break; end
    end
    chk("abort saw 2 pending", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort tx_start", int'(txs[0]), 0);
    chk("abort d_in", int'(din0), 0);
    chk("abort busy (banner)", int'(busys[0]), 1);
    q[0].delete();
    q[1].delete();
    push_banner(0);
    push_banner(1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_idle(3000);

    chk("dut0 queue drained", q[0].size(), 0);
    chk("dut1 queue drained", q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_dec_formatter.md
TX_DEC_FORMATTER -- requirements
Module: tx_dec_formatter

Interface
REQ-001 SHALL have parameter DBIT, default 8, meaning the operand width in bits (legal range 4..16).
REQ-002 SHALL have parameter SIGNED_MODE, default 1, meaning 1 treats the operand as two's complement and 0 treats it as unsigned.
REQ-003 SHALL have parameter PAD_ZEROS, default 0, meaning 1 emits all NDIG digits including leading zeros and 0 suppresses leading zeros.
REQ-004 SHALL have parameter EOL_CRLF, default 1, meaning 1 ends each frame with CR then LF and 0 ends it with CR only.
REQ-005 SHALL have parameter BANNER, default 1, meaning 1 sends the banner "TP 2:" followed by the EOL sequence after reset.
REQ-006 SHALL derive localparam NDIG as the decimal digit count of 2^DBIT-1 (DBIT=8 gives 3, DBIT=16 gives 5).
REQ-007 SHALL have port clk, input, 1 bit, the single system clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-009 SHALL have port tx_done_tick, input, 1 bit, a one-cycle pulse from the UART transmitter when a character completes.
REQ-010 SHALL have port rx_empty, input, 1 bit, a level-sensitive request to format and send the current operand.
REQ-011 SHALL have port leds, input, DBIT bits, the operand value.
REQ-012 SHALL have port d_in, output, 8 bits, the ASCII character presented to the transmitter.
REQ-013 SHALL have port tx_start, output, 1 bit, the request to the transmitter to send d_in.
REQ-014 SHALL have port rd, output, 1 bit, a one-cycle pulse at frame completion.
REQ-015 SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-016 SHALL implement the states BANNER, IDLE, CONVERT, SIGN, DIGIT, EOL_CR and EOL_LF, all registered on clk.
REQ-017 SHALL, in IDLE with rx_empty=1, latch leds into an operand register and enter CONVERT on the next edge.
REQ-018 SHALL ignore rx_empty in every state other than IDLE; requests are neither queued nor counted.
REQ-019 SHALL set the sign flag and take the magnitude as the DBIT-bit unsigned two's-complement negation when SIGNED_MODE=1 and the operand MSB=1; -2^(DBIT-1) SHALL yield magnitude 2^(DBIT-1).
REQ-020 SHALL have CONVERT produce NDIG BCD digits by iterative shift-add-3, taking exactly DBIT cycles, with no hardware divider.
REQ-021 SHALL exit CONVERT to SIGN when the sign flag is set, and to DIGIT otherwise.
REQ-022 SHALL emit digits most significant first, each as its value plus 8'h30.
REQ-023 SHALL, with PAD_ZEROS=0, skip leading zero digits but always emit the least significant digit, so zero emits "0".
REQ-024 SHALL, for each character, drive d_in stable and hold tx_start=1 until the cycle tx_done_tick=1.
REQ-025 SHALL drive tx_start=0 for the cycle after each tx_done_tick before the next character is requested.
REQ-026 SHALL ignore tx_done_tick whenever tx_start=0.
REQ-027 SHALL send CR (8'h0D) in EOL_CR, followed by LF (8'h0A) in EOL_LF when EOL_CRLF=1.
REQ-028 SHALL pulse rd for exactly one cycle on acceptance of the final EOL character and return to IDLE on the same edge.
REQ-029 SHALL have the BANNER state send 'T','P',' ','2',':' and then the EOL sequence, without pulsing rd, then enter IDLE.
REQ-030 SHALL allow rx_empty=1 on the same edge as the return to IDLE to start a new frame on the next edge.

Reset
REQ-031 SHALL, on reset, set d_in=8'h00, tx_start=0, rd=0, the operand, BCD and digit index to 0, and the sign flag to 0, with no pending character retained.
REQ-032 SHALL enter state BANNER after reset when BANNER=1, and IDLE otherwise, with busy=0 in IDLE.
REQ-033 SHALL abort any frame or banner on reset assertion mid-operation; after release the post-reset sequence SHALL restart from its first character.

Verification
REQ-034 SHALL be verified with defaults and a transmitter model answering each tx_start after 10 cycles: reset release -> "TP 2:\r\n" sent, no rd pulse, busy=0 afterwards.
REQ-035 SHALL be verified as: leds=8'h7B, rx_empty pulse -> "123\r\n" sent, one rd pulse; leds=8'h80 -> "-128\r\n"; leds=8'hFF -> "-1\r\n"; leds=8'h00 -> "0\r\n".
REQ-036 SHALL be verified with SIGNED_MODE=0, PAD_ZEROS=1, EOL_CRLF=0, DBIT=16: leds=16'h0005 -> "00005\r"; leds=16'hFFFF -> "65535\r".
REQ-037 SHALL be verified as: rx_empty held high throughout the "123" frame -> exactly one frame, then a second frame starts one cycle after rd.
REQ-038 SHALL be verified as: reset asserted while the digit '2' is pending -> tx_start=0 and d_in=8'h00 immediately; after release the banner is resent from 'T'.
REQ-039 SHALL be verified as: spurious tx_done_tick during CONVERT -> ignored, with no character skipped.
